// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Consumed by uart_rr_pick and uart_tx_arbiter.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_IDX_W   = idx_width(DEFAULT_NUM_REQ);

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first eligible index at or above rr_ptr,
// wrapping from NUM_REQ-1 back to 0. Holds no state.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         eligible,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int GW = idx_width(NUM_REQ);
  localparam int SW = GW + 1;

  logic [SW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest eligible one wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + SW'(k);
      if (cand >= SW'(NUM_REQ)) cand = cand - SW'(NUM_REQ);
      if (eligible[cand[GW-1:0]]) begin
        found = 1'b1;
        index = cand[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Define UART_ARB_PKT_LOCK_EN to hold the grant until a requester's req_last.
//
// state | meaning
// IDLE  | choose a winner among eligible requesters, capture its character
// SEND  | tx_valid high, waiting for tx_ready
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int GW = idx_width(NUM_REQ);

  state_e                state_q, state_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]         grant_id_q, grant_id_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [GW-1:0]         rr_next;

  logic [NUM_REQ-1:0]    eligible;
  logic                  pick_found;
  logic [GW-1:0]         pick_idx;
  logic [DATA_WIDTH-1:0] req_slice [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign rr_next = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);

`ifdef UART_ARB_PKT_LOCK_EN
  logic lock_q, lock_d;
  logic last_q, last_d;

  // While locked, only the requester that owns the packet may be granted.
  assign eligible = lock_q ? (req_valid & (NUM_REQ'(1) << grant_id_q)) : req_valid;
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign eligible    = req_valid;
`endif

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .found    (pick_found),
    .index    (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    req_ready  = '0;
`ifdef UART_ARB_PKT_LOCK_EN
    lock_d     = lock_q;
    last_d     = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          req_ready[pick_idx] = 1'b1;
          tx_data_d           = req_slice[pick_idx];
          grant_id_d          = pick_idx;
          tx_valid_d          = 1'b1;
          state_d             = SEND;
`ifdef UART_ARB_PKT_LOCK_EN
          last_d              = req_last[pick_idx];
`endif
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
`ifdef UART_ARB_PKT_LOCK_EN
          if (last_q) begin
            lock_d   = 1'b0;
            rr_ptr_d = rr_next;
          end else begin
            lock_d   = 1'b1;
          end
`else
          rr_ptr_d   = rr_next;
`endif
        end
      end
    endcase
    // Nothing may be accepted in a reset cycle; the capture would be lost anyway.
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_q     <= 1'b0;
      last_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_q     <= lock_d;
      last_q     <= last_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NUM_REQ=4, DATA_WIDTH=8).
// Expected (grant, character) pairs are queued as stimulus is driven.
module tb_uart_tx_arbiter;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant_id;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    req_data[i*8 +: 8] = d;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = 4'hF;
    req_last  = 4'h0;
    tx_ready  = 1'b0;
    req_data  = 32'h1312_1110;
    tick;
    tick;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    req_valid = 4'h0;
    rst       = 1'b0;
    tick;
  endtask

  task automatic test_round_robin;
    exp_t e;
    int   pulses;
    logic exp_v;
    pulses = 0;
    push(2'd0, 8'h10); push(2'd1, 8'h11); push(2'd2, 8'h12); push(2'd3, 8'h13); push(2'd0, 8'h10);
    req_valid = 4'hF;
    tx_ready  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      exp_v = (c % 2 == 1);
      total++; if (tx_valid !== exp_v) begin bad++; $display("FAIL rr_cadence c=%0d got=%b exp=%b", c, tx_valid, exp_v); end
      if (req_ready !== 4'h0) begin
        pulses++;
        total++;
        if (sb.size() == 0 || req_ready !== (4'b0001 << sb[0].id)) begin
          bad++; $display("FAIL rr_req_ready c=%0d got=%b", c, req_ready);
        end
      end
      if (tx_valid && tx_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL rr_unexpected_tx got id=%0d data=%h", grant_id, tx_data);
        end else begin
          e = sb.pop_front();
          if (grant_id !== e.id || tx_data !== e.data) begin
            bad++; $display("FAIL rr_tx got id=%0d data=%h exp id=%0d data=%h", grant_id, tx_data, e.id, e.data);
          end
        end
      end
      tick;
    end
    req_valid = 4'h0;
    total++; if (pulses !== 5) begin bad++; $display("FAIL rr_pulses got=%0d exp=5", pulses); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL rr_leftover got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_backpressure;
    exp_t e;
    set_data(2, 8'hA5);
    req_valid = 4'b0100;
    tx_ready  = 1'b0;
    push(2'd2, 8'hA5);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_select got=%b exp=0100", req_ready); end
    tick;
    req_valid = 4'h0;
    set_data(2, 8'h5A);
    for (int c = 0; c < 6; c++) begin
      if (c == 5) tx_ready = 1'b1;
      #1;
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || req_ready !== 4'h0) begin
        bad++; $display("FAIL bp_hold c=%0d got v=%b d=%h rdy=%b exp v=1 d=a5 rdy=0000", c, tx_valid, tx_data, req_ready);
      end
      if (tx_valid && tx_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL bp_unexpected_tx got id=%0d data=%h", grant_id, tx_data);
        end else begin
          e = sb.pop_front();
          if (grant_id !== e.id || tx_data !== e.data) begin
            bad++; $display("FAIL bp_tx got id=%0d data=%h exp id=%0d data=%h", grant_id, tx_data, e.id, e.data);
          end
        end
      end
      tick;
    end
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%b exp=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rr_wrap;
    exp_t e;
    req_valid = 4'b0011;
    tx_ready  = 1'b1;
    push(2'd0, 8'h10);
    push(2'd1, 8'h11);
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c == 0) begin
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_grant0 got=%b exp=0001", req_ready); end
      end
      if (c == 2) begin
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wrap_ptr1 got=%b exp=0010", req_ready); end
      end
      if (tx_valid && tx_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL wrap_unexpected_tx got id=%0d data=%h", grant_id, tx_data);
        end else begin
          e = sb.pop_front();
          if (grant_id !== e.id || tx_data !== e.data) begin
            bad++; $display("FAIL wrap_tx got id=%0d data=%h exp id=%0d data=%h", grant_id, tx_data, e.id, e.data);
          end
        end
      end
      tick;
    end
    req_valid = 4'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (tx_valid !== 1'b0 || req_ready !== 4'h0) begin
        bad++; $display("FAIL idle_quiet c=%0d got v=%b rdy=%b exp v=0 rdy=0000", c, tx_valid, req_ready);
      end
      tick;
    end
    req_valid = 4'hF;
    push(2'd2, 8'h5A);
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL idle_ptr_kept got=%b exp=0100", req_ready); end
    tick;
    #1;
    total++;
    if (!(tx_valid && tx_ready) || sb.size() == 0) begin
      bad++; $display("FAIL idle_tx got v=%b exp v=1", tx_valid);
    end else begin
      e = sb.pop_front();
      if (grant_id !== e.id || tx_data !== e.data) begin
        bad++; $display("FAIL idle_tx got id=%0d data=%h exp id=%0d data=%h", grant_id, tx_data, e.id, e.data);
      end
    end
    tick;
    req_valid = 4'h0;
  endtask

  task automatic test_reset_mid_send;
    set_data(3, 8'hC3);
    req_valid = 4'b1000;
    tx_ready  = 1'b0;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL rms_select got=%b exp=1000", req_ready); end
    tick;
    req_valid = 4'h0;
    #1;
    total++; if (tx_valid !== 1'b1 || grant_id !== 2'd3) begin bad++; $display("FAIL rms_send got v=%b id=%0d exp v=1 id=3", tx_valid, grant_id); end
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0 || grant_id !== 2'd0) begin bad++; $display("FAIL rms_after got v=%b id=%0d exp v=0 id=0", tx_valid, grant_id); end
    tx_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rms_discard c=%0d got=%b exp=0", c, tx_valid); end
      tick;
    end
  endtask

  task automatic test_packet;
    exp_t e;
    logic adv;
    int   n;
    set_data(0, 8'h30);
    req_valid = 4'b0001;
    tx_ready  = 1'b1;
    push(2'd0, 8'h30);
    for (int c = 0; c < 2; c++) begin
      #1;
      if (tx_valid && tx_ready) begin
        total++;
        e = sb.pop_front();
        if (grant_id !== e.id || tx_data !== e.data) begin
          bad++; $display("FAIL pkt_pre_tx got id=%0d data=%h exp id=%0d data=%h", grant_id, tx_data, e.id, e.data);
        end
      end
      tick;
    end
`ifdef UART_ARB_PKT_LOCK_EN
    push(2'd1, 8'h41); push(2'd1, 8'h42); push(2'd1, 8'h43); push(2'd0, 8'h30);
`else
    push(2'd1, 8'h41); push(2'd0, 8'h30); push(2'd1, 8'h42); push(2'd0, 8'h30); push(2'd1, 8'h43);
`endif
    n = 0;
    set_data(1, 8'h41);
    req_last  = 4'b0000;
    req_valid = 4'b0011;
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      #1;
      adv = req_ready[1];
      if (tx_valid && tx_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL pkt_unexpected_tx got id=%0d data=%h", grant_id, tx_data);
        end else begin
          e = sb.pop_front();
          if (grant_id !== e.id || tx_data !== e.data) begin
            bad++; $display("FAIL pkt_tx got id=%0d data=%h exp id=%0d data=%h", grant_id, tx_data, e.id, e.data);
          end
        end
      end
      tick;
      if (adv) begin
        n++;
        if (n == 3) begin
          req_valid[1] = 1'b0;
          req_last[1]  = 1'b0;
        end else begin
          set_data(1, 8'h41 + 8'(n));
          req_last[1] = (n == 2);
        end
      end
    end
    req_valid = 4'h0;
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL pkt_timeout left=%0d exp=0", sb.size()); end
    total++; if (n !== 3) begin bad++; $display("FAIL pkt_req1_count got=%0d exp=3", n); end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_backpressure;
    test_rr_wrap;
    test_reset_mid_send;
    test_packet;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
